// File: rtl/config_bit_loader.sv
// rtl/config_bit_loader.sv - sync-word hunting serial loader with atomic ConfigBits commit
module config_bit_loader #(
    parameter int                   NoConfigBits = 4,
    parameter int                   SyncWidth    = 8,
    parameter logic [SyncWidth-1:0] SyncWord     = 8'hA5
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    SerialData,
    input  logic                    SerialValid,
    input  logic                    SerialAbort,
    output logic [NoConfigBits-1:0] ConfigBits,
    output logic                    Busy,
    output logic                    Done,
    output logic                    Configured
);

    localparam int FW = $clog2(SyncWidth + 1);
    localparam int CW = $clog2(NoConfigBits + 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(SyncWidth);
    localparam logic [CW-1:0] LAST_BIT  = CW'(NoConfigBits - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMMIT
    } state_t;

    state_t                  state_q, state_d;
    logic [SyncWidth-1:0]    window_q, window_d;
    logic [FW-1:0]           fill_q, fill_d;
    logic [CW-1:0]           count_q, count_d;
    logic [NoConfigBits-1:0] shadow_q, shadow_d;
    logic                    commit;
    logic [SyncWidth-1:0]    shifted;
    logic [FW-1:0]           fill_inc;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        window_d = window_q;
        fill_d   = fill_q;
        count_d  = count_q;
        shadow_d = shadow_q;
        commit   = 1'b0;
        shifted  = {window_q[SyncWidth-2:0], SerialData};
        fill_inc = (fill_q == FILL_FULL) ? fill_q : fill_q + FW'(1);

        case (state_q)
            ST_IDLE: begin
                if (SerialAbort) begin
                    window_d = '0;
                    fill_d   = '0;
                end else if (SerialValid) begin
                    // Fill gate keeps an all-zero SyncWord from matching the cleared window.
                    if (shifted == SyncWord && fill_inc == FILL_FULL) begin
                        state_d  = ST_LOAD;
                        count_d  = '0;
                        shadow_d = '0;
                        window_d = '0;
                        fill_d   = '0;
                    end else begin
                        window_d = shifted;
                        fill_d   = fill_inc;
                    end
                end
            end
            ST_LOAD: begin
                if (SerialAbort) begin
                    state_d  = ST_IDLE;
                    shadow_d = '0;
                    count_d  = '0;
                end else if (SerialValid) begin
                    for (int i = 0; i < NoConfigBits; i++) begin
                        if (count_q == CW'(i)) begin
                            shadow_d[i] = SerialData;
                        end
                    end
                    if (count_q == LAST_BIT) begin
                        state_d = ST_COMMIT;
                        count_d = '0;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
            end
            ST_COMMIT: begin
                state_d  = ST_IDLE;
                commit   = 1'b1;
                window_d = '0;
                fill_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            window_q   <= '0;
            fill_q     <= '0;
            count_q    <= '0;
            shadow_q   <= '0;
            ConfigBits <= '0;
            Done       <= 1'b0;
            Configured <= 1'b0;
        end else begin
            window_q <= window_d;
            fill_q   <= fill_d;
            count_q  <= count_d;
            shadow_q <= shadow_d;
            Done     <= commit;
            // Whole-vector update keeps downstream BELs from seeing a partial load.
            if (commit) begin
                ConfigBits <= shadow_q;
                Configured <= 1'b1;
            end
        end
    end

    assign Busy = (state_q != ST_IDLE);

endmodule

// File: doc/config_bit_loader.md
Name: config_bit_loader

Overview:
- Serial configuration writer that produces the `ConfigBits` vector consumed by configuration-access BELs, which export those bits to the fabric top.
- Hunts a serial stream for a sync word, then shifts in exactly `NoConfigBits` payload bits into a shadow register.
- Commits the shadow register to `ConfigBits` atomically, so downstream logic never sees a partially loaded vector.
- Sits between the external configuration source and the BEL's GLOBAL `ConfigBits` input.

Parameters:
- NoConfigBits, 4, number of configuration bits loaded and driven.
- SyncWidth, 8, width of the sync pattern in bits.
- SyncWord, 8'hA5, sync pattern, transmitted MSB first.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- SerialData  input  1  serial stream bit.
- SerialValid  input  1  SerialData is accepted on an edge where this is high and the block is in IDLE or LOAD.
- SerialAbort  input  1  abandons hunting or loading; ignored in COMMIT.
- ConfigBits  output  NoConfigBits  committed configuration vector.
- Busy  output  1  high in LOAD and COMMIT.
- Done  output  1  one-cycle pulse, coincident with a ConfigBits update.
- Configured  output  1  sticky; high after the first successful commit since reset.

Behaviour:
- Reset (asynchronous, active-high):
  - ConfigBits = 0, Done = 0, Busy = 0, Configured = 0.
  - State = IDLE; sync window, fill counter, bit counter and shadow all cleared.
- States are IDLE, LOAD and COMMIT. Busy is decoded from state, so it is registered-state-derived.
- IDLE (sync hunt):
  - On each accepted bit: window <= {window[SyncWidth-2:0], SerialData}; fill counter increments, saturating at SyncWidth.
  - Sync is detected when the next window equals SyncWord and the fill count including this bit is at least SyncWidth. The state moves to LOAD at that same edge, with bit counter = 0.
  - The fill gate is required: a SyncWord of all zeros must not match immediately after reset.
  - Overlapping hunts are allowed: a partial or wrong match simply keeps shifting, and a later correct pattern locks.
- LOAD:
  - On each accepted bit: shadow[count] <= SerialData (LSB first) and count increments.
  - When the accepted bit has count == NoConfigBits-1, the state moves to COMMIT.
  - SerialValid low stalls the load with no timeout.
  - Payload bits are never examined for sync.
- COMMIT (exactly one cycle):
  - At the edge leaving COMMIT: ConfigBits <= shadow, Done <= 1, Configured <= 1, state <= IDLE.
  - Sync window and fill counter are cleared on re-entering IDLE.
  - SerialValid and SerialAbort are ignored during COMMIT; the sender must observe Busy.
- Latency: if the last payload bit is accepted at edge k, ConfigBits and Done update at edge k+1. Done deasserts at edge k+2 unless a further commit occurs.
- Abort:
  - In LOAD: return to IDLE, discard the shadow, leave ConfigBits and Configured unchanged.
  - In IDLE: clear the window and fill counter.
  - Abort has priority over SerialValid in the same cycle; that bit is dropped.
- Reset mid-LOAD or mid-COMMIT forces the full reset values immediately; a commit in flight is lost.
- ConfigBits changes only at a commit edge or on reset, never bit by bit.
- Counter widths are sized as clog2(NoConfigBits+1) and clog2(SyncWidth+1), with no wrap inside a frame.

Test Plan:
1. Assert reset for 3 cycles -> ConfigBits=0, Done=0, Busy=0, Configured=0; assert reset asynchronously mid-cycle -> outputs clear before the next edge.
2. Back-to-back valid, bits 1,0,1,0,0,1,0,1 then 1,0,1,1 -> Busy high from the edge after the 8th bit; ConfigBits=4'b1101 and Done high for exactly one cycle, one edge after the last payload bit; Configured=1.
3. Same stream with SerialValid randomly low about 50% of the time -> identical final ConfigBits=4'b1101, a single Done pulse, and no ConfigBits change before the commit.
4. After test 2, send sync then 0,1 then abort -> Busy falls, ConfigBits stays 4'b1101, no Done; then send sync plus 0,0,1,0 -> ConfigBits=4'b0100.
5. Garbage prefix 1,1,0,1 followed by a correct sync locks and loads; a sync with its last bit flipped (0xA4) -> no LOAD and no Done; an all-zero input stream with SyncWord=0 matches only after 8 accepted bits.
6. Assert reset after 2 payload bits of a second frame -> ConfigBits=0 and Configured=0 immediately; a subsequent full frame loads correctly.
